astra_pifo_ingress: RTL and testbench
=====================================

// Module: astra_pifo_ingress
// PURPOSE
//  Ingress/issue stage directly upstream of the Astra PIFO root node. Buffers client pushes
//  in a small FIFO, accepts client pop requests, and issues push, pop or concurrent push-pop
//  commands to the root node at most once per cycle. Tracks tree occupancy against CAP and
//  returns popped entries on a valid/ready result port.
// PARAMETERS
//  PTW   16   priority tag width (LSBs of an entry)
//  MTW   32   metadata width (MSBs of an entry)
//  CAP   340  total tree capacity in entries (4+16+64+256)
//  QD    4    push-queue depth, power of two, >=2
// PORTS
//  i_clk             in   1        clock
//  i_arst_n          in   1        reset; one clock, asynchronous, active-low
//  s_push_valid      in   1        client push request
//  s_push_ready      out  1        push accepted when valid&ready
//  s_push_data       in   MTW+PTW  {meta, prio}
//  s_pop_valid       in   1        client pop request
//  s_pop_ready       out  1        pop issued to node this cycle
//  m_pop_valid       out  1        popped entry available
//  m_pop_ready       in   1        client consumes entry
//  m_pop_data        out  MTW+PTW  popped entry
//  o_node_push       out  1        to node i_push
//  o_node_pop        out  1        to node i_pop
//  o_node_push_data  out  MTW+PTW  to node i_push_data
//  i_node_pop_data   in   MTW+PTW  from node o_pop_data (registered in node, held between pops)
//  i_node_ready      in   1        from node o_ready; no command issued while low
//  o_count           out  $clog2(CAP+1)  entries resident in tree (excludes push queue)
//  o_empty / o_full  out  1        o_count==0 / o_count==CAP
// BEHAVIOUR
//  Reset: all outputs 0 except o_empty=1; queue emptied, count=0, result flag cleared. s_push_ready
//   rises the first cycle after reset release. Mid-operation reset discards queue and result.
//  Push queue: accepts when not full (s_push_ready = ~q_full, independent of s_push_valid). FIFO order.
//   Priority 2^PTW-1 is reserved (marks empty node slots); an accepted tag equal to it is stored
//   as 2^PTW-2. Metadata passes unchanged.
//  res_free = ~m_pop_valid | m_pop_ready.
//  pop_ok  = s_pop_valid & res_free & i_node_ready & (count>0 | ~q_empty).
//  push_ok = ~q_empty & i_node_ready & (count<CAP | pop_ok).
//  Issue (combinational, registered at node): o_node_push=push_ok, o_node_pop=pop_ok,
//   o_node_push_data = queue head; head dequeued when push_ok. s_pop_ready = pop_ok.
//  Both set -> node swap; count unchanged. Covers count==CAP (swap only) and count==0 with a
//   queued entry (swap returns the pushed entry since its tag < reserved tag).
//  Push only: count+1. Pop only: count-1. Count never wraps; pop-only at count==0 and push-only
//   at count==CAP cannot be issued.
//  Result: m_pop_valid <= pop_ok | (m_pop_valid & ~m_pop_ready). m_pop_data = i_node_pop_data
//   (pass-through; the node holds it until the next pop, which is issued only when res_free).
//   Latency: pop issued in cycle T -> m_pop_valid in T+1. Sustained 1 pop/cycle with m_pop_ready=1.
//  Same-cycle enqueue and dequeue of the queue are legal at any fill level except full, where
//   enqueue is refused (no bypass).
//  Client pop with count==0 and queue empty stalls (s_pop_ready=0) until a push is enqueued.
// STRUCTURE
//  Package astra_pifo_pkg:
//   - entry_t packed struct {meta[MTW], prio[PTW]}
//   - PRIO_RESERVED = '1 and PRIO_CLAMP = PRIO_RESERVED-1
//   - CNTW function of CAP
//  Sub-module astra_sync_fifo (width MTW+PTW, depth QD):
//   - registered full/empty, async active-low reset
//   - the push queue
//  Top:
//   - issue logic, occupancy counter, result flag
// TESTING
//  1 reset, push prio 5,2,9 with pop idle -> 3 node pushes, o_count=3; then 3 pops with m_pop_ready=1
//    -> m_pop_data prio 2,5,9 on consecutive cycles, o_empty=1.
//  2 fill to CAP, push prio 7 with no pop -> o_node_push=0, entry held in queue; pop -> swap issued,
//    o_count stays CAP, queue drains.
//  3 count=0, queue empty, s_pop_valid=1 -> s_pop_ready=0; push prio 3 -> swap issued,
//    m_pop_data prio 3, o_count 0.
//  4 m_pop_ready=0 with result pending, s_pop_valid=1 -> no pop issued, m_pop_data stable;
//    m_pop_ready=1 -> next pop issued the same cycle.
//  5 push prio 16'hFFFF -> node receives 16'hFFFE, meta unchanged.
//  6 QD+1 back-to-back pushes at count=CAP -> s_push_ready=0 after QD accepted;
//    assert i_arst_n low mid-stream -> all outputs reset, o_count=0.

Source files
------------

// File: rtl/astra_pifo_pkg.sv
// Shared types and constants for the Astra PIFO ingress stage.
// Entries are {meta, prio}; the all-ones priority tag is reserved for empty node slots.
package astra_pifo_pkg;

  localparam int PTW = 16;
  localparam int MTW = 32;
  localparam int CAP = 340;
  localparam int QD  = 4;

  typedef struct packed {
    logic [MTW-1:0] meta;
    logic [PTW-1:0] prio;
  } entry_t;

  localparam logic [PTW-1:0] PRIO_RESERVED = '1;
  localparam logic [PTW-1:0] PRIO_CLAMP    = PRIO_RESERVED - PTW'(1);

  function automatic int cntw(input int cap);
    return $clog2(cap + 1);
  endfunction

  localparam int CNTW = cntw(CAP);

endpackage

// File: rtl/astra_sync_fifo.sv
// Synchronous FIFO with registered full/empty; read data is the head, dequeued by rd_rdy.
// Zero read latency; writes refused while full, reads ignored while empty.
module astra_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             do_wr, do_rd;

  assign do_wr  = wr_vld & ~full;
  assign do_rd  = rd_rdy & ~empty;
  assign wr_nxt = wr_ptr + AW'(1);
  assign rd_nxt = rd_ptr + AW'(1);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  // Flags only move when exactly one side is active; simultaneous read+write keeps fill level.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_nxt;
      if (do_rd) rd_ptr <= rd_nxt;
      if (do_wr && !do_rd) begin
        empty <= 1'b0;
        full  <= (wr_nxt == rd_ptr);
      end else if (do_rd && !do_wr) begin
        full  <= 1'b0;
        empty <= (rd_nxt == wr_ptr);
      end
    end
  end

endmodule

// File: rtl/astra_pifo_ingress.sv
// Issue stage ahead of the PIFO root: queues pushes, issues push/pop/swap once per cycle, tracks occupancy.
// Pop result valid one cycle after issue; no pop issued while the result slot is held by m_pop_ready=0.
module astra_pifo_ingress #(
  parameter int PTW = astra_pifo_pkg::PTW,
  parameter int MTW = astra_pifo_pkg::MTW,
  parameter int CAP = astra_pifo_pkg::CAP,
  parameter int QD  = astra_pifo_pkg::QD
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     s_push_valid,
  output logic                     s_push_ready,
  input  logic [MTW+PTW-1:0]       s_push_data,
  input  logic                     s_pop_valid,
  output logic                     s_pop_ready,
  output logic                     m_pop_valid,
  input  logic                     m_pop_ready,
  output logic [MTW+PTW-1:0]       m_pop_data,
  output logic                     o_node_push,
  output logic                     o_node_pop,
  output logic [MTW+PTW-1:0]       o_node_push_data,
  input  logic [MTW+PTW-1:0]       i_node_pop_data,
  input  logic                     i_node_ready,
  output logic [$clog2(CAP+1)-1:0] o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  import astra_pifo_pkg::*;

  localparam int CW = cntw(CAP);

  entry_t        in_ent, wr_ent, head;
  logic          push_en, q_full, q_empty, enq;
  logic          res_vld, res_free, pop_ok, push_ok;
  logic [CW-1:0] count;

  always_comb begin
    in_ent = entry_t'(s_push_data);
    wr_ent = in_ent;
    if (in_ent.prio == PRIO_RESERVED) wr_ent.prio = PRIO_CLAMP;
  end

  // Holds s_push_ready low while reset is asserted and for the first edge after release.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) push_en <= 1'b0;
    else           push_en <= 1'b1;
  end

  assign s_push_ready = push_en & ~q_full;
  assign enq          = s_push_valid & s_push_ready;

  astra_sync_fifo #(
    .WIDTH (MTW + PTW),
    .DEPTH (QD)
  ) u_push_q (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .wr_vld   (enq),
    .wr_dat   (wr_ent),
    .rd_rdy   (push_ok),
    .rd_dat   (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign res_free = ~res_vld | m_pop_ready;
  assign pop_ok   = s_pop_valid & res_free & i_node_ready & ((count != '0) | ~q_empty);
  assign push_ok  = ~q_empty & i_node_ready & ((count != CW'(CAP)) | pop_ok);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      count   <= '0;
      res_vld <= 1'b0;
    end else begin
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
      res_vld <= pop_ok | (res_vld & ~m_pop_ready);
    end
  end

  assign s_pop_ready      = pop_ok;
  assign o_node_push      = push_ok;
  assign o_node_pop       = pop_ok;
  assign o_node_push_data = push_ok ? head : '0;
  // The node holds its pop register between pops, so the result passes straight through.
  assign m_pop_valid      = res_vld;
  assign m_pop_data       = res_vld ? i_node_pop_data : '0;
  assign o_count          = count;
  assign o_empty          = (count == '0);
  assign o_full           = (count == CW'(CAP));

endmodule

// File: tb/tb_astra_pifo_ingress.sv
// Directed bench for astra_pifo_ingress with a behavioural PIFO root node model.
module tb_astra_pifo_ingress;
  import astra_pifo_pkg::*;

  localparam int W = MTW + PTW;

  logic            i_clk = 1'b0;
  logic            i_arst_n = 1'b0;
  logic            s_push_valid = 1'b0;
  logic            s_push_ready;
  logic [W-1:0]    s_push_data = '0;
  logic            s_pop_valid = 1'b0;
  logic            s_pop_ready;
  logic            m_pop_valid;
  logic            m_pop_ready = 1'b1;
  logic [W-1:0]    m_pop_data;
  logic            o_node_push, o_node_pop;
  logic [W-1:0]    o_node_push_data;
  logic [W-1:0]    node_pop_data;
  logic            i_node_ready = 1'b1;
  logic [CNTW-1:0] o_count;
  logic            o_empty, o_full;

  int n_chk = 0;
  int n_pass = 0;

  astra_pifo_ingress dut (
    .i_clk            (i_clk),
    .i_arst_n         (i_arst_n),
    .s_push_valid     (s_push_valid),
    .s_push_ready     (s_push_ready),
    .s_push_data      (s_push_data),
    .s_pop_valid      (s_pop_valid),
    .s_pop_ready      (s_pop_ready),
    .m_pop_valid      (m_pop_valid),
    .m_pop_ready      (m_pop_ready),
    .m_pop_data       (m_pop_data),
    .o_node_push      (o_node_push),
    .o_node_pop       (o_node_pop),
    .o_node_push_data (o_node_push_data),
    .i_node_pop_data  (node_pop_data),
    .i_node_ready     (i_node_ready),
    .o_count          (o_count),
    .o_empty          (o_empty),
    .o_full           (o_full)
  );

  always #5 i_clk = ~i_clk;

  // Root node model: commands sampled mid-cycle, applied on the edge; pop returns the minimum tag.
  logic   cmd_push = 1'b0, cmd_pop = 1'b0;
  entry_t cmd_dat = '0;
  entry_t node_q[$];
  int     mi;

  always @(negedge i_clk) begin
    cmd_push = o_node_push;
    cmd_pop  = o_node_pop;
    cmd_dat  = entry_t'(o_node_push_data);
  end

  always @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      node_q.delete();
      node_pop_data <= '0;
    end else if (cmd_pop) begin
      mi = -1;
      for (int k = 0; k < node_q.size(); k++)
        if (mi < 0 || node_q[k].prio < node_q[mi].prio) mi = k;
      if (mi < 0 || (cmd_push && cmd_dat.prio < node_q[mi].prio)) begin
        node_pop_data <= cmd_dat;
      end else begin
        node_pop_data <= node_q[mi];
        node_q.delete(mi);
        if (cmd_push) node_q.push_back(cmd_dat);
      end
    end else if (cmd_push) begin
      node_q.push_back(cmd_dat);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill();
    s_push_valid = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      s_push_data = {32'(i), 16'd100};
      cyc();
    end
    s_push_valid = 1'b0;
    repeat (3) cyc();
    chk("fill_count", 64'(o_count), 64'(CAP));
    chk("fill_full", 64'(o_full), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  logic [15:0] pr [3];
  logic [15:0] ex [3];
  int acc;

  initial begin
    pr[0] = 16'd5; pr[1] = 16'd2; pr[2] = 16'd9;
    ex[0] = 16'd2; ex[1] = 16'd5; ex[2] = 16'd9;

    // Reset state
    cyc();
    chk("rst_push_ready", 64'(s_push_ready), 64'd0);
    chk("rst_empty", 64'(o_empty), 64'd1);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_m_valid", 64'(m_pop_valid), 64'd0);
    chk("rst_node_push", 64'(o_node_push), 64'd0);
    cyc();
    i_arst_n = 1'b1;
    @(negedge i_clk);
    chk("rel_push_ready_lo", 64'(s_push_ready), 64'd0);
    cyc();
    @(negedge i_clk);
    chk("rel_push_ready_hi", 64'(s_push_ready), 64'd1);
    cyc();

    // 1: push 5,2,9 then pop in priority order
    for (int i = 0; i < 3; i++) begin
      s_push_valid = 1'b1;
      s_push_data  = {32'h100 + 32'(i), pr[i]};
      @(negedge i_clk);
      if (i > 0) begin
        chk("t1_node_push", 64'(o_node_push), 64'd1);
        chk("t1_push_prio", 64'(o_node_push_data[15:0]), 64'(pr[i-1]));
      end
      cyc();
    end
    s_push_valid = 1'b0;
    @(negedge i_clk);
    chk("t1_push_prio_last", 64'(o_node_push_data[15:0]), 64'd9);
    cyc(); cyc();
    @(negedge i_clk);
    chk("t1_count3", 64'(o_count), 64'd3);
    chk("t1_idle", 64'(o_node_push), 64'd0);
    cyc();
    m_pop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_pop_valid = 1'b1;
      @(negedge i_clk);
      chk("t1_pop_ready", 64'(s_pop_ready), 64'd1);
      if (i > 0) begin
        chk("t1_m_valid", 64'(m_pop_valid), 64'd1);
        chk("t1_pop_prio", 64'(m_pop_data[15:0]), 64'(ex[i-1]));
      end
      cyc();
    end
    s_pop_valid = 1'b0;
    @(negedge i_clk);
    chk("t1_pop_prio_last", 64'(m_pop_data[15:0]), 64'(ex[2]));
    chk("t1_empty", 64'(o_empty), 64'd1);
    cyc();
    @(negedge i_clk);
    chk("t1_m_valid_drop", 64'(m_pop_valid), 64'd0);
    cyc();

    // 2: full tree holds a push until a pop allows a swap
    fill();
    s_push_valid = 1'b1;
    s_push_data  = {32'h7777, 16'd7};
    @(negedge i_clk);
    chk("t2_push_ready", 64'(s_push_ready), 64'd1);
    cyc();
    s_push_valid = 1'b0;
    cyc();
    @(negedge i_clk);
    chk("t2_push_held", 64'(o_node_push), 64'd0);
    chk("t2_count_cap", 64'(o_count), 64'(CAP));
    cyc();
    s_pop_valid = 1'b1;
    @(negedge i_clk);
    chk("t2_swap_push", 64'(o_node_push), 64'd1);
    chk("t2_swap_pop", 64'(o_node_pop), 64'd1);
    chk("t2_swap_data", 64'(o_node_push_data), {16'd0, 32'h7777, 16'd7});
    cyc();
    s_pop_valid = 1'b0;
    @(negedge i_clk);
    chk("t2_count_after", 64'(o_count), 64'(CAP));
    chk("t2_result", 64'(m_pop_data[15:0]), 64'd7);
    chk("t2_q_drained", 64'(o_node_push), 64'd0);
    cyc();

    // 3: pop stalls on an empty system until a push arrives, then swaps
    s_pop_valid = 1'b1;
    for (int k = 0; k < CAP + 20 && o_count != 0; k++) cyc();
    @(negedge i_clk);
    chk("t3_drained", 64'(o_count), 64'd0);
    chk("t3_stall", 64'(s_pop_ready), 64'd0);
    cyc();
    s_push_valid = 1'b1;
    s_push_data  = {32'hAAAA0003, 16'd3};
    @(negedge i_clk);
    chk("t3_no_bypass", 64'(s_pop_ready), 64'd0);
    cyc();
    s_push_valid = 1'b0;
    @(negedge i_clk);
    chk("t3_pop_issue", 64'(s_pop_ready), 64'd1);
    chk("t3_push_issue", 64'(o_node_push), 64'd1);
    cyc();
    s_pop_valid = 1'b0;
    @(negedge i_clk);
    chk("t3_result", 64'(m_pop_data), {16'd0, 32'hAAAA0003, 16'd3});
    chk("t3_count0", 64'(o_count), 64'd0);
    cyc();

    // 4: held result blocks further pops
    s_push_valid = 1'b1;
    s_push_data  = {32'h40, 16'd40};
    cyc();
    s_push_data  = {32'h30, 16'd30};
    cyc();
    s_push_valid = 1'b0;
    cyc(); cyc();
    @(negedge i_clk);
    chk("t4_count2", 64'(o_count), 64'd2);
    cyc();
    m_pop_ready = 1'b0;
    s_pop_valid = 1'b1;
    @(negedge i_clk);
    chk("t4_first_pop", 64'(s_pop_ready), 64'd1);
    cyc();
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      chk("t4_blocked", 64'(s_pop_ready), 64'd0);
      chk("t4_held_valid", 64'(m_pop_valid), 64'd1);
      chk("t4_held_data", 64'(m_pop_data[15:0]), 64'd30);
      cyc();
    end
    m_pop_ready = 1'b1;
    @(negedge i_clk);
    chk("t4_same_cycle_pop", 64'(s_pop_ready), 64'd1);
    cyc();
    s_pop_valid = 1'b0;
    @(negedge i_clk);
    chk("t4_second", 64'(m_pop_data[15:0]), 64'd40);
    chk("t4_count0", 64'(o_count), 64'd0);
    cyc();

    // 5: reserved tag is clamped; node not-ready blocks issue
    s_push_valid = 1'b1;
    s_push_data  = {32'hDEADBEEF, 16'hFFFF};
    cyc();
    s_push_valid = 1'b0;
    i_node_ready = 1'b0;
    @(negedge i_clk);
    chk("t5_not_ready", 64'(o_node_push), 64'd0);
    cyc();
    i_node_ready = 1'b1;
    @(negedge i_clk);
    chk("t5_clamp", 64'(o_node_push_data), {16'd0, 32'hDEADBEEF, 16'hFFFE});
    cyc(); cyc();
    s_pop_valid = 1'b1;
    cyc();
    s_pop_valid = 1'b0;
    @(negedge i_clk);
    chk("t5_pop_clamped", 64'(m_pop_data), {16'd0, 32'hDEADBEEF, 16'hFFFE});
    cyc();

    // 6: queue fills at CAP, then reset mid-stream
    fill();
    acc = 0;
    s_push_valid = 1'b1;
    for (int i = 0; i < QD + 1; i++) begin
      s_push_data = {32'h600 + 32'(i), 16'd50};
      @(negedge i_clk);
      chk("t6_push_ready", 64'(s_push_ready), (i < QD) ? 64'd1 : 64'd0);
      if (s_push_ready) acc++;
      cyc();
    end
    chk("t6_accepted", 64'(acc), 64'(QD));
    i_arst_n = 1'b0;
    #1;
    chk("t6_rst_push_ready", 64'(s_push_ready), 64'd0);
    chk("t6_rst_count", 64'(o_count), 64'd0);
    chk("t6_rst_empty", 64'(o_empty), 64'd1);
    chk("t6_rst_full", 64'(o_full), 64'd0);
    chk("t6_rst_node_push", 64'(o_node_push), 64'd0);
    chk("t6_rst_m_valid", 64'(m_pop_valid), 64'd0);
    s_push_valid = 1'b0;
    cyc();
    i_arst_n = 1'b1;
    cyc();
    @(negedge i_clk);
    chk("t6_rel_push_ready", 64'(s_push_ready), 64'd1);
    chk("t6_rel_q_empty", 64'(o_node_push), 64'd0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
